// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port plus the IF/ID stage outputs and decode/execute controls.
interface instruction_fetch_unit_if;
  logic [15:0] inst_address;
  logic [31:0] read_data;
  logic        stall;
  logic        branch_taken;
  logic [14:0] branch_target;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic [15:0] fetch_count;

  // Fetch unit side.
  modport master (
    output inst_address,
    input  read_data,
    input  stall,
    input  branch_taken,
    input  branch_target,
    output if_instr,
    output if_pc,
    output if_valid,
    output halted,
    output fetch_count
  );

  // Memory / pipeline side.
  modport slave (
    input  inst_address,
    output read_data,
    output stall,
    output branch_taken,
    output branch_target,
    input  if_instr,
    input  if_pc,
    input  if_valid,
    input  halted,
    input  fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address and
// registers the returned word into the IF/ID pipeline register.
module instruction_fetch_unit #(
  parameter int unsigned PROG_LEN = 14,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                            clk,
  input  logic                            reset,
  instruction_fetch_unit_if.master        bus
);

  localparam logic [15:0] LastPc = 16'(PROG_LEN - 1);
  localparam logic [15:0] EndPc  = 16'(PROG_LEN);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // PC and IF/ID pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_instr_q    <= 32'h0;
      if_pc_q       <= 16'h0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= 16'h0;
    end else begin
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state and datapath update: branch > stall > normal fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_valid_d    = if_valid_q;
    fetch_count_d = fetch_count_q;

    if (bus.branch_taken) begin
      // Redirect flushes the wrong-path word but keeps the last delivered one visible.
      pc_d       = {1'b0, bus.branch_target};
      if_valid_d = 1'b0;
      state_d    = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (!bus.stall) begin
            if_instr_d = bus.read_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            if (fetch_count_q != 16'hFFFF) begin
              fetch_count_d = fetch_count_q + 16'd1;
            end
            // >= so an out-of-range branch target still fetches one word then halts.
            if (pc_q >= LastPc) begin
              state_d = StHalt;
              pc_d    = EndPc;
            end else begin
              pc_d = pc_q + 16'd1;
            end
          end
        end
        StHalt: begin
          if_valid_d = 1'b0;
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // Outputs come straight from registers; no combinational path from stall or branch.
  always_comb begin
    bus.inst_address = pc_q;
    bus.if_instr     = if_instr_q;
    bus.if_pc        = if_pc_q;
    bus.if_valid     = if_valid_q;
    bus.halted       = (state_q == StHalt);
    bus.fetch_count  = fetch_count_q;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .PROG_LEN(14),
    .RESET_PC(16'h0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory model: word k holds 32'h1000_0000 + k.
  assign bus.read_data = 32'h1000_0000 + {16'h0, bus.inst_address};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [14:0] tgt;
    logic [15:0] addr;
    logic [31:0] instr;
    logic [15:0] ifpc;
    logic        valid;
    logic        halted;
    logic [15:0] count;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] w(input int k);
    return 32'h1000_0000 + 32'(k);
  endfunction

  task automatic add(input logic s, input logic b, input int tgt, input int addr,
                     input int k, input int ifpc, input logic v, input logic h, input int cnt);
    vec_t e;
    e.stall  = s;
    e.br     = b;
    e.tgt    = 15'(tgt);
    e.addr   = 16'(addr);
    e.instr  = w(k);
    e.ifpc   = 16'(ifpc);
    e.valid  = v;
    e.halted = h;
    e.count  = 16'(cnt);
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int idx, input logic [15:0] addr,
                           input logic [31:0] instr, input logic [15:0] ifpc,
                           input logic valid, input logic halted, input logic [15:0] cnt);
    check({name, ".addr"},   idx, 32'(bus.inst_address), 32'(addr));
    check({name, ".instr"},  idx, bus.if_instr, instr);
    check({name, ".if_pc"},  idx, 32'(bus.if_pc), 32'(ifpc));
    check({name, ".valid"},  idx, 32'(bus.if_valid), 32'(valid));
    check({name, ".halted"}, idx, 32'(bus.halted), 32'(halted));
    check({name, ".count"},  idx, 32'(bus.fetch_count), 32'(cnt));
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 15'd0;
    step();
    step();
    check_all("reset", 0, 16'd0, 32'h0, 16'd0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;

    //  stall br tgt addr word ifpc v h cnt
    add(0, 0, 0,  1,  0,  0, 1, 0, 1);
    add(0, 0, 0,  2,  1,  1, 1, 0, 2);
    add(0, 0, 0,  3,  2,  2, 1, 0, 3);
    add(0, 0, 0,  4,  3,  3, 1, 0, 4);
    add(0, 0, 0,  5,  4,  4, 1, 0, 5);
    add(1, 0, 0,  5,  4,  4, 1, 0, 5);   // stall hold x3 at pc=5
    add(1, 0, 0,  5,  4,  4, 1, 0, 5);
    add(1, 0, 0,  5,  4,  4, 1, 0, 5);
    add(0, 0, 0,  6,  5,  5, 1, 0, 6);   // word 5, no dup/skip
    add(0, 0, 0,  7,  6,  6, 1, 0, 7);
    add(0, 0, 0,  8,  7,  7, 1, 0, 8);
    add(0, 0, 0,  9,  8,  8, 1, 0, 9);
    add(0, 0, 0, 10,  9,  9, 1, 0, 10);
    add(0, 1, 13, 13, 9,  9, 0, 0, 10);  // forward branch at pc=10
    add(0, 0, 0, 14, 13, 13, 1, 1, 11);  // word 13 delivered, halt
    add(0, 0, 0, 14, 13, 13, 0, 1, 11);
    add(1, 0, 0, 14, 13, 13, 0, 1, 11);  // stall ignored in HALT
    add(0, 1, 0,  0, 13, 13, 0, 0, 11);  // branch leaves HALT
    add(0, 0, 0,  1,  0,  0, 1, 0, 12);
    add(1, 1, 2,  2,  0,  0, 0, 0, 12);  // branch beats stall
    add(0, 0, 0,  3,  2,  2, 1, 0, 13);
    add(0, 1, 13, 13, 2,  2, 0, 0, 13);
    add(0, 1, 7,  7,  2,  2, 0, 0, 13);  // backward loop from pc=13
    add(0, 0, 0,  8,  7,  7, 1, 0, 14);
    add(0, 0, 0,  9,  8,  8, 1, 0, 15);
    add(0, 0, 0, 10,  9,  9, 1, 0, 16);
    add(0, 0, 0, 11, 10, 10, 1, 0, 17);
    add(0, 0, 0, 12, 11, 11, 1, 0, 18);
    add(0, 0, 0, 13, 12, 12, 1, 0, 19);
    add(0, 0, 0, 14, 13, 13, 1, 1, 20);
    add(0, 1, 20, 20, 13, 13, 0, 0, 20); // target beyond PROG_LEN
    add(0, 0, 0, 14, 20, 20, 1, 1, 21);

    foreach (vecs[i]) begin
      bus.stall         = vecs[i].stall;
      bus.branch_taken  = vecs[i].br;
      bus.branch_target = vecs[i].tgt;
      step();
      check_all("vec", i, vecs[i].addr, vecs[i].instr, vecs[i].ifpc, vecs[i].valid,
                vecs[i].halted, vecs[i].count);
    end
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;

    // Mid-run reset while stalled at pc=6.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("pre_reset.addr", 0, 32'(bus.inst_address), 32'd6);
    bus.stall = 1'b1;
    reset     = 1'b1;
    step();
    check_all("mid_reset", 0, 16'd0, 32'h0, 16'd0, 1'b0, 1'b0, 16'd0);
    reset     = 1'b0;
    bus.stall = 1'b0;

    // Straight-line fetch of the whole program.
    for (int n = 1; n <= 14; n++) begin
      step();
      check_all("line", n, (n == 14) ? 16'd14 : 16'(n), w(n - 1), 16'(n - 1), 1'b1,
                (n == 14), 16'(n));
    end
    for (int n = 0; n < 3; n++) begin
      step();
      check_all("halt", n, 16'd14, w(13), 16'd13, 1'b0, 1'b1, 16'd14);
    end

    // Saturation: preload the counter just below max, then keep fetching.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 15'd0;
    step();
    bus.branch_taken = 1'b0;
    force dut.fetch_count_q = 16'hFFFE;
    #1;
    release dut.fetch_count_q;
    for (int n = 0; n < 3; n++) begin
      step();
      check("sat.count", n, 32'(bus.fetch_count), 32'h0000_FFFF);
      check("sat.addr",  n, 32'(bus.inst_address), 32'(n + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read port.
- Owns the program counter and drives the 16-bit instruction address to the instruction memory. The memory returns 32-bit data combinationally.
- Registers the returned word into an IF/ID pipeline register for the decoder.
- Handles decode-stage stalls, absolute branch redirects from the 15-bit branch target field, and end-of-program halt.

Parameters:
- PROG_LEN, 14, number of valid instruction words. The fetch unit halts once the PC reaches this value.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- inst_address  output  16  address to instruction memory; always equals the current PC register.
- read_data  input  32  instruction word from memory, valid in the same cycle as inst_address.
- stall  input  1  decode stage cannot accept; hold the PC and the IF/ID register.
- branch_taken  input  1  redirect request from the execute stage.
- branch_target  input  15  absolute target word address; zero-extended to 16 bits.
- if_instr  output  32  registered instruction to decode.
- if_pc  output  16  address that if_instr was fetched from.
- if_valid  output  1  if_instr holds a real instruction (0 = bubble).
- halted  output  1  fetch has stopped at PROG_LEN.
- fetch_count  output  16  number of instructions delivered with if_valid=1; saturates at 16'hFFFF.

Behaviour:
- Reset values: pc=RESET_PC, if_instr=0, if_pc=0, if_valid=0, halted=0, fetch_count=0, state=RUN. Reset overrides every other input in the same cycle.
- States:
  - RUN: fetching.
  - HALT: PC frozen, only bubbles output.
- Priority each edge: reset > branch_taken > stall > normal fetch.
- RUN, normal fetch (no stall, no branch):
  - if_instr <= read_data, if_pc <= pc, if_valid <= 1, pc <= pc+1, fetch_count += 1 (saturating).
  - Latency: the word at address A appears on if_instr one cycle after inst_address=A.
- RUN, stall=1 and branch_taken=0:
  - pc, if_instr, if_pc, if_valid and fetch_count all hold.
  - No memory word is consumed.
- branch_taken=1, in any state and regardless of stall:
  - pc <= {1'b0, branch_target}; if_valid <= 0 (the wrong-path word is flushed); if_instr and if_pc hold.
  - fetch_count is not incremented; state <= RUN; halted <= 0.
- HALT transition:
  - When a normal fetch delivers the word at pc == PROG_LEN-1, the next state is HALT.
  - That word itself is delivered with if_valid=1.
  - On entry to HALT: halted <= 1, pc <= PROG_LEN.
- HALT, no branch:
  - if_valid <= 0 every cycle; pc, if_instr and if_pc hold.
  - stall has no effect.
- PC wrap-around: pc+1 is modulo 2^16, so 16'hFFFF increments to 16'h0000. This only matters when PROG_LEN > 16'hFFFF is configured out; PROG_LEN must be ≤ 65535.
- A branch_target ≥ PROG_LEN is legal. The unit fetches that one word, delivers it with if_valid=1, and enters HALT on the next normal fetch (the comparison is pc ≥ PROG_LEN-1).
- Reset during stall or HALT fully reinitialises; there is no residual bubble beyond if_valid=0.
- inst_address is the combinational output of the pc register only. There is no path from stall or branch_taken to it.

Test Plan:
- Straight-line fetch:
  - Stimulus: release reset; memory word k = 32'h1000_0000+k; hold stall=0.
  - Required: cycle n≥1 shows if_pc=n-1, if_instr=32'h1000_0000+(n-1), if_valid=1.
  - Required: after 14 fetches halted=1, fetch_count=14, inst_address=14, and if_valid=0 thereafter.
- Stall hold:
  - Stimulus: assert stall for 3 cycles while pc=5.
  - Required: inst_address stays 5, and if_pc/if_instr hold the word from address 4 for 3 cycles.
  - Required: on release, the word at address 5 arrives with no duplicate and no skip; fetch_count increments by exactly 1.
- Forward branch:
  - Stimulus: at pc=10, pulse branch_taken with branch_target=15'd13.
  - Required: next cycle if_valid=0 and inst_address=13; the following cycle if_pc=13 with if_valid=1.
- Backward loop:
  - Stimulus: at pc=13, branch_target=15'd7.
  - Required: the PC sequence continues 7, 8, 9…
  - Required: halted is not asserted until address 13 is delivered without a branch.
- Branch wins over stall and leaves HALT:
  - Stimulus (a): stall=1 and branch_taken=1 with target=2 in the same cycle. Required: pc=2, if_valid=0.
  - Stimulus (b): while halted=1, branch_taken with target=0. Required: halted=0 and fetching resumes at address 0.
- Mid-run reset:
  - Stimulus: assert reset at pc=6 with stall=1.
  - Required: next cycle pc=0, if_valid=0, fetch_count=0, halted=0.
- Saturation:
  - Stimulus: preload fetch_count near its maximum (force or long run) to 16'hFFFF.
  - Required: fetch_count stays at 16'hFFFF on further fetches.
